rgbw_frame_decoder: RTL and testbench

- Sits directly downstream of the SPI slave receiver.
- Consumes each received byte (data + rdy), assembles fixed-format lamp command frames and validates them.
- On a good frame, atomically commits the seven control fields (mode, lint, colorIdx, red, green, blue, white) to output registers that feed the color generator.
- Bad, short or stalled frames are discarded and counted.

---
 rtl/rgbw_frame_decoder_if.sv | 9 +
 rtl/rgbw_frame_decoder.sv | 177 +++++++++++++++++
 tb/tb_rgbw_frame_decoder.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rgbw_frame_decoder_if.sv
// Byte stream from the SPI slave receiver into the RGBW lamp frame decoder.
// The receiver side is the master; the decoder consumes through the slave modport.
interface rgbw_frame_decoder_if;
  logic [7:0] rx_data;
  logic       rx_rdy;

  modport master (output rx_data, output rx_rdy);
  modport slave  (input  rx_data, input  rx_rdy);
endinterface

// File: rtl/rgbw_frame_decoder.sv
// Assembles lamp command frames from SPI bytes and atomically commits the seven
// control fields. Define RGBW_FRAME_CHECKSUM_EN for the 9-byte checksummed frame.
module rgbw_frame_decoder #(
  parameter logic [7:0] HEADER  = 8'hA5,
  parameter int         TIMEOUT = 4096,
  parameter int         TO_W    = 13
) (
  input  logic                clk,
  input  logic                reset,
  rgbw_frame_decoder_if.slave rx,
  output logic [7:0]          mode_o,
  output logic [7:0]          lint_o,
  output logic [7:0]          colorIdx_o,
  output logic [7:0]          red_o,
  output logic [7:0]          green_o,
  output logic [7:0]          blue_o,
  output logic [7:0]          white_o,
  output logic                frame_ok,
  output logic                frame_err,
  output logic [7:0]          err_cnt
);

`ifdef RGBW_FRAME_CHECKSUM_EN
  localparam int NSH = 7;
  typedef enum logic [1:0] {S_IDLE, S_PAYLOAD, S_CHECK, S_COMMIT} state_t;
`else
  // The white byte is committed straight from the bus, so only six shadows exist.
  localparam int NSH = 6;
  typedef enum logic [1:0] {S_IDLE, S_PAYLOAD, S_COMMIT} state_t;
`endif

  state_t          state_q;
  logic            rdy_q;
  logic [TO_W-1:0] to_cnt_q;
  logic [2:0]      idx_q;
  logic [7:0]      shadow_q [NSH];
  logic [7:0]      mode_q, lint_q, color_q, red_q, green_q, blue_q, white_q;
  logic            frame_ok_q, frame_err_q;
  logic [7:0]      err_cnt_q;

  logic            byte_stb;
  logic            to_exp;
  logic [7:0]      err_cnt_d;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? 8'hFF : v + 8'd1;
  endfunction

  assign byte_stb  = rx.rx_rdy & ~rdy_q;
  assign to_exp    = (to_cnt_q == TO_W'(TIMEOUT - 1));
  assign err_cnt_d = sat_inc(err_cnt_q);

`ifdef RGBW_FRAME_CHECKSUM_EN
  logic [7:0] acc_q;
  logic [7:0] acc_d;
  logic [7:0] sum_d;

  assign acc_d = acc_q + rx.rx_data;
  assign sum_d = acc_q + rx.rx_data;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      rdy_q       <= 1'b0;
      to_cnt_q    <= '0;
      idx_q       <= '0;
      for (int i = 0; i < NSH; i++) shadow_q[i] <= 8'h00;
      mode_q      <= 8'h00;
      lint_q      <= 8'h00;
      color_q     <= 8'h00;
      red_q       <= 8'h00;
      green_q     <= 8'h00;
      blue_q      <= 8'h00;
      white_q     <= 8'h00;
      frame_ok_q  <= 1'b0;
      frame_err_q <= 1'b0;
      err_cnt_q   <= 8'h00;
`ifdef RGBW_FRAME_CHECKSUM_EN
      acc_q       <= 8'h00;
`endif
    end else begin
      rdy_q       <= rx.rx_rdy;
      frame_ok_q  <= 1'b0;
      frame_err_q <= 1'b0;
      case (state_q)
        // COMMIT lasts one cycle and already behaves like IDLE for a new header.
        S_IDLE, S_COMMIT: begin
          state_q  <= S_IDLE;
          to_cnt_q <= '0;
          if (byte_stb && (rx.rx_data == HEADER)) begin
            state_q <= S_PAYLOAD;
            idx_q   <= '0;
`ifdef RGBW_FRAME_CHECKSUM_EN
            acc_q   <= 8'h00;
`endif
          end
        end

        S_PAYLOAD: begin
          if (byte_stb) begin
            to_cnt_q <= '0;
            idx_q    <= idx_q + 3'd1;
`ifdef RGBW_FRAME_CHECKSUM_EN
            shadow_q[idx_q] <= rx.rx_data;
            acc_q           <= acc_d;
            if (idx_q == 3'd6) state_q <= S_CHECK;
`else
            if (idx_q == 3'd6) begin
              mode_q     <= shadow_q[0];
              lint_q     <= shadow_q[1];
              color_q    <= shadow_q[2];
              red_q      <= shadow_q[3];
              green_q    <= shadow_q[4];
              blue_q     <= shadow_q[5];
              white_q    <= rx.rx_data;
              frame_ok_q <= 1'b1;
              state_q    <= S_COMMIT;
            end else begin
              shadow_q[idx_q] <= rx.rx_data;
            end
`endif
          end else if (to_exp) begin
            state_q     <= S_IDLE;
            frame_err_q <= 1'b1;
            err_cnt_q   <= err_cnt_d;
          end else begin
            to_cnt_q <= to_cnt_q + 1'b1;
          end
        end

`ifdef RGBW_FRAME_CHECKSUM_EN
        S_CHECK: begin
          if (byte_stb) begin
            to_cnt_q <= '0;
            if (sum_d == 8'h00) begin
              mode_q     <= shadow_q[0];
              lint_q     <= shadow_q[1];
              color_q    <= shadow_q[2];
              red_q      <= shadow_q[3];
              green_q    <= shadow_q[4];
              blue_q     <= shadow_q[5];
              white_q    <= shadow_q[6];
              frame_ok_q <= 1'b1;
              state_q    <= S_COMMIT;
            end else begin
              frame_err_q <= 1'b1;
              err_cnt_q   <= err_cnt_d;
              state_q     <= S_IDLE;
            end
          end else if (to_exp) begin
            state_q     <= S_IDLE;
            frame_err_q <= 1'b1;
            err_cnt_q   <= err_cnt_d;
          end else begin
            to_cnt_q <= to_cnt_q + 1'b1;
          end
        end
`endif

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign mode_o     = mode_q;
  assign lint_o     = lint_q;
  assign colorIdx_o = color_q;
  assign red_o      = red_q;
  assign green_o    = green_q;
  assign blue_o     = blue_q;
  assign white_o    = white_q;
  assign frame_ok   = frame_ok_q;
  assign frame_err  = frame_err_q;
  assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_rgbw_frame_decoder.sv
// Self-checking bench for rgbw_frame_decoder: a frame-level reference model is
// compared against every output on every cycle, plus literal spot checks.
`timescale 1ns/1ps
module tb_rgbw_frame_decoder;
  localparam logic [7:0] HDR = 8'hA5;
  localparam int         TMO = 100;
`ifdef RGBW_FRAME_CHECKSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif
  localparam int NBODY = CSUM ? 8 : 7;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  rgbw_frame_decoder_if rxif ();
  logic [7:0] mode_o, lint_o, colorIdx_o, red_o, green_o, blue_o, white_o, err_cnt;
  logic       frame_ok, frame_err;

  rgbw_frame_decoder #(.HEADER(HDR), .TIMEOUT(TMO), .TO_W(8)) dut (
    .clk(clk), .reset(reset), .rx(rxif),
    .mode_o(mode_o), .lint_o(lint_o), .colorIdx_o(colorIdx_o),
    .red_o(red_o), .green_o(green_o), .blue_o(blue_o), .white_o(white_o),
    .frame_ok(frame_ok), .frame_err(frame_err), .err_cnt(err_cnt)
  );

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;
  int cyc = 0;

  typedef struct { int edge_n; logic [7:0] b; } stb_t;
  stb_t       sq [$];
  bit         in_frame = 1'b0;
  logic [7:0] fb [$];
  int         last_e = 0;
  logic [7:0] ef [7];
  int         ecnt = 0;
  bit         eok = 1'b0, eerr = 1'b0;
  logic [7:0] pl [7];

  // Reference model: reacts to each scheduled byte arrival at its clock edge.
  initial begin : model
    stb_t       t;
    bit         stb;
    logic [7:0] mb;
    logic [7:0] s;
    for (int i = 0; i < 7; i++) ef[i] = 8'h00;
    forever begin
      @(posedge clk);
      cyc++;
      eok  = 1'b0;
      eerr = 1'b0;
      if (reset) begin
        in_frame = 1'b0;
        fb.delete();
        sq.delete();
        ecnt = 0;
        for (int i = 0; i < 7; i++) ef[i] = 8'h00;
      end else begin
        stb = 1'b0;
        mb  = 8'h00;
        if (sq.size() > 0 && sq[0].edge_n == cyc) begin
          t   = sq.pop_front();
          stb = 1'b1;
          mb  = t.b;
        end
        if (!in_frame) begin
          if (stb && mb == HDR) begin
            in_frame = 1'b1;
            fb.delete();
            last_e = cyc;
          end
        end else if (stb) begin
          fb.push_back(mb);
          last_e = cyc;
          if (fb.size() == NBODY) begin
            in_frame = 1'b0;
            s = 8'h00;
            foreach (fb[i]) s = s + fb[i];
            if (!CSUM || s == 8'h00) begin
              for (int i = 0; i < 7; i++) ef[i] = fb[i];
              eok = 1'b1;
            end else begin
              eerr = 1'b1;
              if (ecnt < 255) ecnt++;
            end
          end
        end else if (cyc - last_e == TMO) begin
          in_frame = 1'b0;
          eerr = 1'b1;
          if (ecnt < 255) ecnt++;
        end
      end
    end
  end

  initial begin : compare
    logic [55:0] gf, wf;
    logic        wok, werr;
    logic [7:0]  wcnt;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        gf = {mode_o, lint_o, colorIdx_o, red_o, green_o, blue_o, white_o};
        if (reset) begin
          wf = '0; wok = 1'b0; werr = 1'b0; wcnt = 8'h00;
        end else begin
          wf   = {ef[0], ef[1], ef[2], ef[3], ef[4], ef[5], ef[6]};
          wok  = eok;
          werr = eerr;
          wcnt = 8'(ecnt);
        end
        vectors++;
        if (gf !== wf || frame_ok !== wok || frame_err !== werr || err_cnt !== wcnt) begin
          miscompares++;
          $display("FAIL cycle_check cyc=%0d: got fields=%h ok=%b err=%b cnt=%h, want fields=%h ok=%b err=%b cnt=%h",
                   cyc, gf, frame_ok, frame_err, err_cnt, wf, wok, werr, wcnt);
        end
      end
    end
  end

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic chk_frame(input string tag);
    chk({tag, "_mode"},  mode_o,     pl[0]);
    chk({tag, "_lint"},  lint_o,     pl[1]);
    chk({tag, "_color"}, colorIdx_o, pl[2]);
    chk({tag, "_red"},   red_o,      pl[3]);
    chk({tag, "_green"}, green_o,    pl[4]);
    chk({tag, "_blue"},  blue_o,     pl[5]);
    chk({tag, "_white"}, white_o,    pl[6]);
  endtask

  // rx_rdy is high for 'hold' sampled edges, then low for at least one edge.
  task automatic send_byte(input logic [7:0] b, input int hold, input int gap);
    stb_t t;
    @(posedge clk);
    #1;
    rxif.rx_data = b;
    rxif.rx_rdy  = 1'b1;
    t.edge_n = cyc + 1;
    t.b      = b;
    sq.push_back(t);
    repeat (hold) @(posedge clk);
    #1;
    rxif.rx_rdy  = 1'b0;
    rxif.rx_data = 8'($urandom);
    repeat (gap) @(posedge clk);
  endtask

  function automatic logic [7:0] csum_of();
    logic [7:0] s;
    s = 8'h00;
    for (int i = 0; i < 7; i++) s = s + pl[i];
    return 8'h00 - s;
  endfunction

  task automatic send_frame(input int hmin, input int hmax, input int gmax, input logic [7:0] cs);
    send_byte(HDR, $urandom_range(hmax, hmin), $urandom_range(gmax, 0));
    for (int i = 0; i < 7; i++) send_byte(pl[i], $urandom_range(hmax, hmin), $urandom_range(gmax, 0));
    if (CSUM) send_byte(cs, $urandom_range(hmax, hmin), $urandom_range(gmax, 0));
  endtask

  task automatic settle();
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin : main
    int         e1;
    int         kind;
    int         nb;
    logic [7:0] jb;
    rxif.rx_rdy  = 1'b0;
    rxif.rx_data = 8'h00;
    @(posedge clk);
    chk_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    repeat (20) @(posedge clk);
    #1;
    chk("idle_err_cnt", err_cnt, 8'h00);
    chk("idle_mode", mode_o, 8'h00);
    chk("idle_white", white_o, 8'h00);
    chk("idle_ok", {7'd0, frame_ok}, 8'h00);

    // Payload sums to 8'h2F, so the good checksum byte is 8'hD1.
    pl = '{8'h01, 8'h80, 8'h10, 8'hFF, 8'h00, 8'h7F, 8'h20};
    send_frame(1, 1, 2, 8'hD1);
    settle();
    chk_frame("A");
    chk("A_err_cnt", err_cnt, 8'h00);

    send_frame(1, 1, 2, 8'hD2);
    settle();
    chk_frame("A_bad");
    chk("bad_err_cnt", err_cnt, CSUM ? 8'h01 : 8'h00);
    e1 = CSUM ? 2 : 1;

    send_byte(HDR, 1, 1);
    send_byte(8'h5A, 1, 1);
    send_byte(8'h6B, 1, 1);
    send_byte(8'h7C, 1, 1);
    repeat (TMO + 5) @(posedge clk);
    #1;
    chk("to_err_cnt", err_cnt, 8'(e1));
    chk_frame("A_after_to");
    pl = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE};
    send_frame(1, 2, 1, csum_of());
    settle();
    chk_frame("B");
    chk("B_err_cnt", err_cnt, 8'(e1));

    // Byte spacing of exactly TMO edges is still accepted; header bytes inside are data.
    pl = '{8'h02, 8'hA5, 8'h03, 8'hA5, 8'h40, 8'h50, 8'h60};
    send_byte(HDR, 1, 0);
    for (int i = 0; i < 7; i++) send_byte(pl[i], 1, (i == 2) ? TMO - 2 : 0);
    if (CSUM) send_byte(csum_of(), 1, 0);
    settle();
    chk_frame("C");
    chk("C_err_cnt", err_cnt, 8'(e1));

    send_byte(HDR, 1, 0);
    send_byte(8'h44, 1, 0);
    send_byte(8'h45, 1, TMO - 1);
    send_byte(8'h33, 1, 0);
    settle();
    chk("edge_to_err_cnt", err_cnt, 8'(e1 + 1));
    chk_frame("C_after_to");

    send_byte(8'h00, 5, 1);
    send_byte(8'hA4, 5, 1);
    pl = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77};
    send_frame(5, 5, 1, csum_of());
    settle();
    chk_frame("D");
    chk("D_err_cnt", err_cnt, 8'(e1 + 1));

    for (int k = 0; k < 40; k++) begin
      kind = $urandom_range(9, 0);
      nb   = $urandom_range(3, 0);
      for (int j = 0; j < nb; j++) begin
        jb = 8'($urandom);
        if (jb == HDR) jb = 8'h00;
        send_byte(jb, $urandom_range(3, 1), $urandom_range(3, 0));
      end
      for (int i = 0; i < 7; i++) pl[i] = 8'($urandom);
      if (kind == 0) begin
        nb = $urandom_range(NBODY - 1, 0);
        send_byte(HDR, 1, 0);
        for (int i = 0; i < nb; i++) send_byte(pl[i], $urandom_range(4, 1), $urandom_range(5, 0));
        repeat (TMO + 5) @(posedge clk);
      end else if (kind < 3) begin
        send_frame(1, 4, 5, csum_of() ^ 8'($urandom_range(255, 1)));
      end else begin
        send_frame(1, 4, 5, csum_of());
      end
    end

    pl = '{8'h0F, 8'h1E, 8'h2D, 8'h3C, 8'h4B, 8'h5A, 8'h69};
    send_byte(HDR, 1, 0);
    for (int i = 0; i < 4; i++) send_byte(pl[i], 1, 1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("rst_mode", mode_o, 8'h00);
    chk("rst_lint", lint_o, 8'h00);
    chk("rst_color", colorIdx_o, 8'h00);
    chk("rst_red", red_o, 8'h00);
    chk("rst_green", green_o, 8'h00);
    chk("rst_blue", blue_o, 8'h00);
    chk("rst_white", white_o, 8'h00);
    chk("rst_err_cnt", err_cnt, 8'h00);
    chk("rst_ok", {7'd0, frame_ok}, 8'h00);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    send_frame(1, 3, 2, csum_of());
    settle();
    chk_frame("E");
    chk("E_err_cnt", err_cnt, 8'h00);

    for (int n = 0; n < 301; n++) begin
      if (CSUM) begin
        for (int i = 0; i < 7; i++) pl[i] = 8'($urandom);
        send_frame(1, 1, 0, csum_of() ^ 8'h01);
      end else begin
        send_byte(HDR, 1, 0);
        send_byte(8'h01, 1, 0);
        repeat (TMO + 2) @(posedge clk);
      end
      if (n == 299) begin
        settle();
        chk("sat_err_cnt", err_cnt, 8'hFF);
      end
    end
    settle();
    chk("sat_hold_err_cnt", err_cnt, 8'hFF);

    repeat (5) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
